id_ex_stage: RTL and testbench

//  ID/EX pipeline register with operand forwarding and load-use hazard detection.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/fwd_mux.sv | 46 ++++
 rtl/id_ex_stage.sv | 192 +++++++++++++++++++
 tb/tb_id_ex_stage.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants and types for the ID/EX stage: ALU codes, register zero
// and the forwarding-source select.
package cpu_pkg;

    // ALU operation codes
    localparam logic [2:0] ADDU = 3'b000;
    localparam logic [2:0] ADD  = 3'b001;
    localparam logic [2:0] OR   = 3'b010;
    localparam logic [2:0] SUBU = 3'b100;
    localparam logic [2:0] SUB  = 3'b101;
    localparam logic [2:0] SLTU = 3'b110;
    localparam logic [2:0] SLT  = 3'b111;

    // Hard-wired zero register; never a forwarding target
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Where an ALU operand comes from
    typedef enum logic [1:0] {
        FWD_RF,
        FWD_EXMEM,
        FWD_MEMWB
    } fwd_sel_e;

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding for one source register: compares the register against
// the EX/MEM and MEM/WB destinations and selects the newest value.
module fwd_mux
    import cpu_pkg::*;
#(
    parameter int unsigned DW = 32,
    parameter int unsigned RW = 5
) (
    input  logic [RW-1:0] src,
    input  logic [DW-1:0] rf_data,
    input  logic          exmem_regwrite,
    input  logic [RW-1:0] exmem_rd,
    input  logic [DW-1:0] exmem_result,
    input  logic          memwb_regwrite,
    input  logic [RW-1:0] memwb_rd,
    input  logic [DW-1:0] memwb_data,
    output logic [DW-1:0] data
);

    fwd_sel_e sel;
    logic     hit_exmem;
    logic     hit_memwb;

    // Source selection: EX/MEM is younger than MEM/WB, so it wins a dual match
    always_comb begin
        hit_exmem = exmem_regwrite & (exmem_rd != RW'(REG_ZERO)) & (exmem_rd == src);
        hit_memwb = memwb_regwrite & (memwb_rd != RW'(REG_ZERO)) & (memwb_rd == src);
        sel       = FWD_RF;
        if (hit_exmem) begin
            sel = FWD_EXMEM;
        end else if (hit_memwb) begin
            sel = FWD_MEMWB;
        end
    end

    // 3:1 operand mux
    always_comb begin
        data = rf_data;
        unique case (sel)
            FWD_EXMEM: data = exmem_result;
            FWD_MEMWB: data = memwb_data;
            default:   data = rf_data;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use hazard detection,
// bubble insertion on hazards and flushes, and a saturating bubble counter.
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int unsigned DW    = 32,
    parameter int unsigned RW    = 5,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    // decoded instruction from ID
    input  logic             id_valid,
    input  logic [RW-1:0]    id_rs,
    input  logic [RW-1:0]    id_rt,
    input  logic             id_rt_used,
    input  logic [RW-1:0]    id_rd,
    input  logic [DW-1:0]    id_rs_data,
    input  logic [DW-1:0]    id_rt_data,
    input  logic [DW-1:0]    id_imm,
    input  logic             id_alusrc,
    input  logic [2:0]       id_aluctr,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             id_memwrite,
    input  logic             id_memtoreg,
    input  logic             flush,
    // later stages, for forwarding
    input  logic             exmem_regwrite,
    input  logic [RW-1:0]    exmem_rd,
    input  logic [DW-1:0]    exmem_result,
    input  logic             memwb_regwrite,
    input  logic [RW-1:0]    memwb_rd,
    input  logic [DW-1:0]    memwb_data,
    // outputs
    output logic             stall,
    output logic [DW-1:0]    alu_a,
    output logic [DW-1:0]    alu_b,
    output logic [2:0]       alu_ctr,
    output logic             ex_valid,
    output logic             ex_regwrite,
    output logic             ex_memread,
    output logic             ex_memwrite,
    output logic             ex_memtoreg,
    output logic [RW-1:0]    ex_rd,
    output logic [DW-1:0]    ex_store_data,
    output logic [CNT_W-1:0] bubble_cnt
);

    // control half of the ID/EX register
    logic             valid_q;
    logic             regwrite_q;
    logic             memread_q;
    logic             memwrite_q;
    logic             memtoreg_q;
    logic [2:0]       aluctr_q;
    logic [RW-1:0]    rd_q;
    // data half of the ID/EX register
    logic [RW-1:0]    rs_q;
    logic [RW-1:0]    rt_q;
    logic [DW-1:0]    rs_data_q;
    logic [DW-1:0]    rt_data_q;
    logic [DW-1:0]    imm_q;
    logic             alusrc_q;

    logic [CNT_W-1:0] bubble_cnt_q;
    logic [CNT_W-1:0] bubble_cnt_d;

    logic             haz;
    logic             load;
    logic [DW-1:0]    fwd_rs;
    logic [DW-1:0]    fwd_rt;

    // Load-use hazard against the load currently in EX; flush overrides stall
    always_comb begin
        haz   = valid_q & memread_q & (rd_q != RW'(REG_ZERO)) & id_valid &
                ((rd_q == id_rs) | (id_rt_used & (rd_q == id_rt)));
        stall = haz & ~flush;
        load  = id_valid & ~stall & ~flush;
    end

    // Control register: capture the ID instruction or insert a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            aluctr_q   <= 3'b000;
            rd_q       <= '0;
        end else if (load) begin
            valid_q    <= 1'b1;
            regwrite_q <= id_regwrite;
            memread_q  <= id_memread;
            memwrite_q <= id_memwrite;
            memtoreg_q <= id_memtoreg;
            aluctr_q   <= id_aluctr;
            rd_q       <= id_rd;
        end else begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            aluctr_q   <= ADDU;
            rd_q       <= '0;
        end
    end

    // Data register: only updated on capture, a bubble leaves it untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs_q      <= '0;
            rt_q      <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            alusrc_q  <= 1'b0;
        end else if (load) begin
            rs_q      <= id_rs;
            rt_q      <= id_rt;
            rs_data_q <= id_rs_data;
            rt_data_q <= id_rt_data;
            imm_q     <= id_imm;
            alusrc_q  <= id_alusrc;
        end
    end

    // Count bubbles caused by a hazard or flush, holding at all-ones
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if ((haz | flush) && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + 1'b1;
        end
    end

    // Bubble counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    fwd_mux #(
        .DW (DW),
        .RW (RW)
    ) u_fwd_rs (
        .src            (rs_q),
        .rf_data        (rs_data_q),
        .exmem_regwrite (exmem_regwrite),
        .exmem_rd       (exmem_rd),
        .exmem_result   (exmem_result),
        .memwb_regwrite (memwb_regwrite),
        .memwb_rd       (memwb_rd),
        .memwb_data     (memwb_data),
        .data           (fwd_rs)
    );

    fwd_mux #(
        .DW (DW),
        .RW (RW)
    ) u_fwd_rt (
        .src            (rt_q),
        .rf_data        (rt_data_q),
        .exmem_regwrite (exmem_regwrite),
        .exmem_rd       (exmem_rd),
        .exmem_result   (exmem_result),
        .memwb_regwrite (memwb_regwrite),
        .memwb_rd       (memwb_rd),
        .memwb_data     (memwb_data),
        .data           (fwd_rt)
    );

    // Operand and registered-control outputs
    always_comb begin
        alu_a         = fwd_rs;
        alu_b         = alusrc_q ? imm_q : fwd_rt;
        ex_store_data = fwd_rt;
        alu_ctr       = aluctr_q;
        ex_valid      = valid_q;
        ex_regwrite   = regwrite_q;
        ex_memread    = memread_q;
        ex_memwrite   = memwrite_q;
        ex_memtoreg   = memtoreg_q;
        ex_rd         = rd_q;
        bubble_cnt    = bubble_cnt_q;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized
// traffic, all compared against an instruction-level model of the EX slot.
module tb_id_ex_stage;
    import cpu_pkg::*;

    localparam int unsigned DW    = 32;
    localparam int unsigned RW    = 5;
    localparam int unsigned CNT_W = 16;

    logic          clk;
    logic          rst_n;
    logic          id_valid, id_rt_used, id_alusrc;
    logic [RW-1:0] id_rs, id_rt, id_rd;
    logic [DW-1:0] id_rs_data, id_rt_data, id_imm;
    logic [2:0]    id_aluctr;
    logic          id_regwrite, id_memread, id_memwrite, id_memtoreg;
    logic          flush;
    logic          exmem_regwrite, memwb_regwrite;
    logic [RW-1:0] exmem_rd, memwb_rd;
    logic [DW-1:0] exmem_result, memwb_data;
    logic          stall;
    logic [DW-1:0] alu_a, alu_b, ex_store_data;
    logic [2:0]    alu_ctr;
    logic          ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg;
    logic [RW-1:0] ex_rd;
    logic [CNT_W-1:0] bubble_cnt;

    id_ex_stage #(
        .DW    (DW),
        .RW    (RW),
        .CNT_W (CNT_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_valid       (id_valid),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_rt_used     (id_rt_used),
        .id_rd          (id_rd),
        .id_rs_data     (id_rs_data),
        .id_rt_data     (id_rt_data),
        .id_imm         (id_imm),
        .id_alusrc      (id_alusrc),
        .id_aluctr      (id_aluctr),
        .id_regwrite    (id_regwrite),
        .id_memread     (id_memread),
        .id_memwrite    (id_memwrite),
        .id_memtoreg    (id_memtoreg),
        .flush          (flush),
        .exmem_regwrite (exmem_regwrite),
        .exmem_rd       (exmem_rd),
        .exmem_result   (exmem_result),
        .memwb_regwrite (memwb_regwrite),
        .memwb_rd       (memwb_rd),
        .memwb_data     (memwb_data),
        .stall          (stall),
        .alu_a          (alu_a),
        .alu_b          (alu_b),
        .alu_ctr        (alu_ctr),
        .ex_valid       (ex_valid),
        .ex_regwrite    (ex_regwrite),
        .ex_memread     (ex_memread),
        .ex_memwrite    (ex_memwrite),
        .ex_memtoreg    (ex_memtoreg),
        .ex_rd          (ex_rd),
        .ex_store_data  (ex_store_data),
        .bubble_cnt     (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction currently occupying EX, as the model sees it
    typedef struct {
        logic        valid;
        logic        regwrite, memread, memwrite, memtoreg, alusrc;
        logic [4:0]  rd, rs, rt;
        logic [31:0] rs_data, rt_data, imm;
        logic [2:0]  aluctr;
    } slot_t;

    slot_t       m_ex;
    int unsigned m_cnt;
    logic [31:0] rf [32];
    int unsigned n_checks;
    int unsigned n_pass;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic slot_t bubble_slot();
        slot_t s;
        s = '{default: '0};
        s.aluctr = ADDU;
        return s;
    endfunction

    function automatic logic model_haz();
        return m_ex.valid && m_ex.memread && (m_ex.rd != 5'd0) && id_valid &&
               ((m_ex.rd == id_rs) || (id_rt_used && (m_ex.rd == id_rt)));
    endfunction

    function automatic logic [31:0] model_fwd(input logic [4:0] src, input logic [31:0] rfd);
        if (exmem_regwrite && exmem_rd != 5'd0 && exmem_rd == src) return exmem_result;
        if (memwb_regwrite && memwb_rd != 5'd0 && memwb_rd == src) return memwb_data;
        return rfd;
    endfunction

    // Compare every output against the model for the current inputs
    task automatic check_model(input string tag);
        check_eq({tag, "_stall"}, {31'b0, stall}, {31'b0, model_haz() && !flush});
        check_eq({tag, "_valid"}, {31'b0, ex_valid}, {31'b0, m_ex.valid});
        check_eq({tag, "_ctl"}, {28'b0, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg},
                 {28'b0, m_ex.regwrite, m_ex.memread, m_ex.memwrite, m_ex.memtoreg});
        check_eq({tag, "_aluctr"}, {29'b0, alu_ctr}, {29'b0, m_ex.aluctr});
        check_eq({tag, "_cnt"}, {16'b0, bubble_cnt}, m_cnt);
        if (m_ex.valid) begin
            check_eq({tag, "_rd"}, {27'b0, ex_rd}, {27'b0, m_ex.rd});
            check_eq({tag, "_alu_a"}, alu_a, model_fwd(m_ex.rs, m_ex.rs_data));
            check_eq({tag, "_alu_b"}, alu_b,
                     m_ex.alusrc ? m_ex.imm : model_fwd(m_ex.rt, m_ex.rt_data));
            check_eq({tag, "_store"}, ex_store_data, model_fwd(m_ex.rt, m_ex.rt_data));
        end
    endtask

    // Step the model across one clock edge and return at the next falling edge
    task automatic advance();
        slot_t nxt;
        logic  h;
        h = model_haz();
        if (id_valid && !h && !flush) begin
            nxt.valid    = 1'b1;
            nxt.regwrite = id_regwrite;
            nxt.memread  = id_memread;
            nxt.memwrite = id_memwrite;
            nxt.memtoreg = id_memtoreg;
            nxt.alusrc   = id_alusrc;
            nxt.rd       = id_rd;
            nxt.rs       = id_rs;
            nxt.rt       = id_rt;
            nxt.rs_data  = id_rs_data;
            nxt.rt_data  = id_rt_data;
            nxt.imm      = id_imm;
            nxt.aluctr   = id_aluctr;
        end else begin
            nxt = bubble_slot();
        end
        if ((h || flush) && m_cnt < 32'd65535) m_cnt = m_cnt + 1;
        @(posedge clk);
        m_ex = nxt;
        @(negedge clk);
    endtask

    task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic rt_used,
                          input logic [4:0] rd, input logic alusrc, input logic [31:0] imm,
                          input logic [2:0] ctr, input logic rw, input logic mr,
                          input logic mw, input logic m2r);
        id_valid    = 1'b1;
        id_rs       = rs;
        id_rt       = rt;
        id_rt_used  = rt_used;
        id_rd       = rd;
        id_rs_data  = rf[rs];
        id_rt_data  = rf[rt];
        id_alusrc   = alusrc;
        id_imm      = imm;
        id_aluctr   = ctr;
        id_regwrite = rw;
        id_memread  = mr;
        id_memwrite = mw;
        id_memtoreg = m2r;
    endtask

    task automatic id_nop();
        id_valid    = 1'b0;
        id_regwrite = 1'b0;
        id_memread  = 1'b0;
        id_memwrite = 1'b0;
        id_memtoreg = 1'b0;
    endtask

    task automatic fwd_idle();
        exmem_regwrite = 1'b0;
        memwb_regwrite = 1'b0;
        exmem_rd       = 5'($urandom_range(0, 31));
        memwb_rd       = 5'($urandom_range(0, 31));
        exmem_result   = $urandom;
        memwb_data     = $urandom;
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_ctl"}, {26'b0, ex_valid, ex_regwrite, ex_memread, ex_memwrite,
                 ex_memtoreg, stall}, 32'd0);
        check_eq({tag, "_rd"}, {27'b0, ex_rd}, 32'd0);
        check_eq({tag, "_aluctr"}, {29'b0, alu_ctr}, 32'd0);
        check_eq({tag, "_cnt"}, {16'b0, bubble_cnt}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic        hold;
        int unsigned c0;
        n_checks = 0;
        n_pass   = 0;
        rf[0] = 32'd0;
        for (int i = 1; i < 32; i++) rf[i] = $urandom;
        rst_n = 1'b0;
        flush = 1'b0;
        id_nop();
        id_rs = '0; id_rt = '0; id_rd = '0; id_rt_used = 1'b0; id_alusrc = 1'b0;
        id_rs_data = '0; id_rt_data = '0; id_imm = '0; id_aluctr = '0;
        fwd_idle();
        m_ex  = bubble_slot();
        m_cnt = 0;
        @(negedge clk);
        #1 check_reset_state("rst0");
        @(negedge clk);
        rst_n = 1'b1;

        // EX/MEM forwarding: add $3,$1,$2 then sub $4,$3,$5
        set_id(5'd1, 5'd2, 1'b1, 5'd3, 1'b0, 32'd0, ADD, 1'b1, 1'b0, 1'b0, 1'b0);
        #1 check_model("t2a");
        advance();
        set_id(5'd3, 5'd5, 1'b1, 5'd4, 1'b0, 32'd0, SUB, 1'b1, 1'b0, 1'b0, 1'b0);
        #1 check_model("t2b");
        advance();
        id_nop();
        exmem_regwrite = 1'b1; exmem_rd = 5'd3; exmem_result = 32'h0000_00AA;
        #1;
        check_eq("t2_alu_a", alu_a, 32'h0000_00AA);
        check_eq("t2_alu_ctr", {29'b0, alu_ctr}, {29'b0, SUB});
        check_model("t2c");
        advance();

        // Dual match on $7: EX/MEM beats MEM/WB on both operands
        fwd_idle();
        set_id(5'd7, 5'd7, 1'b1, 5'd10, 1'b0, 32'd0, OR, 1'b1, 1'b0, 1'b0, 1'b0);
        advance();
        id_nop();
        exmem_regwrite = 1'b1; exmem_rd = 5'd7; exmem_result = 32'h11;
        memwb_regwrite = 1'b1; memwb_rd = 5'd7; memwb_data = 32'h22;
        #1;
        check_eq("t3_alu_a", alu_a, 32'h11);
        check_eq("t3_alu_b", alu_b, 32'h11);
        check_eq("t3_store", ex_store_data, 32'h11);
        exmem_regwrite = 1'b0;
        #1 check_eq("t3_memwb_only", alu_a, 32'h22);
        check_model("t3");
        advance();

        // Load-use: lw $8 in EX, add $9,$8,$1 in ID
        fwd_idle();
        set_id(5'd2, 5'd8, 1'b0, 5'd8, 1'b1, 32'd4, ADDU, 1'b1, 1'b1, 1'b0, 1'b1);
        #1 check_model("t4a");
        advance();
        set_id(5'd8, 5'd1, 1'b1, 5'd9, 1'b0, 32'd0, ADD, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        check_eq("t4_stall1", {31'b0, stall}, 32'd1);
        check_model("t4b");
        advance();
        exmem_regwrite = 1'b1; exmem_rd = 5'd8; exmem_result = 32'h0000_1004;
        #1;
        check_eq("t4_stall2", {31'b0, stall}, 32'd0);
        check_eq("t4_bubble", {31'b0, ex_valid}, 32'd0);
        check_eq("t4_cnt", {16'b0, bubble_cnt}, 32'd1);
        check_model("t4c");
        advance();
        id_nop();
        exmem_regwrite = 1'b0;
        memwb_regwrite = 1'b1; memwb_rd = 5'd8; memwb_data = 32'hDEAD_BEEF;
        #1;
        check_eq("t4_valid", {31'b0, ex_valid}, 32'd1);
        check_eq("t4_alu_a", alu_a, 32'hDEAD_BEEF);
        check_model("t4d");
        advance();

        // A write to $0 must never be forwarded
        fwd_idle();
        set_id(5'd0, 5'd0, 1'b1, 5'd11, 1'b0, 32'd0, ADDU, 1'b1, 1'b0, 1'b0, 1'b0);
        advance();
        id_nop();
        exmem_regwrite = 1'b1; exmem_rd = 5'd0; exmem_result = 32'hFFFF_FFFF;
        memwb_regwrite = 1'b1; memwb_rd = 5'd0; memwb_data = 32'h5555_5555;
        #1;
        check_eq("t5_alu_a", alu_a, 32'd0);
        check_eq("t5_alu_b", alu_b, 32'd0);
        check_model("t5");
        advance();

        // Flush together with a load-use hazard
        fwd_idle();
        set_id(5'd1, 5'd12, 1'b0, 5'd12, 1'b1, 32'd8, ADDU, 1'b1, 1'b1, 1'b0, 1'b1);
        advance();
        set_id(5'd12, 5'd3, 1'b1, 5'd13, 1'b0, 32'd0, SUBU, 1'b1, 1'b0, 1'b0, 1'b0);
        flush = 1'b1;
        c0 = m_cnt;
        #1;
        check_eq("t6_stall", {31'b0, stall}, 32'd0);
        check_model("t6a");
        advance();
        flush = 1'b0;
        id_nop();
        #1;
        check_eq("t6_bubble", {31'b0, ex_valid}, 32'd0);
        check_eq("t6_cnt", {16'b0, bubble_cnt}, c0 + 1);
        advance();

        // Randomized traffic; a stalled instruction is held in ID
        hold = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!hold) begin
                set_id(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom),
                       5'($urandom_range(0, 7)), 1'($urandom), $urandom,
                       3'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
                       1'($urandom), 1'($urandom));
                id_valid = ($urandom_range(0, 7) != 0);
            end
            flush          = ($urandom_range(0, 9) == 0);
            exmem_regwrite = 1'($urandom);
            exmem_rd       = 5'($urandom_range(0, 7));
            exmem_result   = $urandom;
            memwb_regwrite = 1'($urandom);
            memwb_rd       = 5'($urandom_range(0, 7));
            memwb_data     = $urandom;
            #1 check_model("rnd");
            hold = model_haz() && !flush;
            advance();
        end
        flush = 1'b0;

        // Reset in mid-cycle with a valid instruction in EX
        fwd_idle();
        set_id(5'd4, 5'd5, 1'b1, 5'd6, 1'b0, 32'd0, SLT, 1'b1, 1'b0, 1'b1, 1'b0);
        advance();
        #1 check_model("t1_pre");
        #2 rst_n = 1'b0;
        m_ex  = bubble_slot();
        m_cnt = 0;
        #1 check_reset_state("t1_async");
        @(posedge clk);
        #1 check_reset_state("t1_hold");
        @(negedge clk);
        rst_n = 1'b1;
        id_nop();
        #1 check_model("t1_post");
        advance();

        // Saturation: 2^CNT_W + 3 flush bubbles
        flush = 1'b1;
        id_valid = 1'b1;
        repeat ((1 << CNT_W) + 3) @(posedge clk);
        @(negedge clk);
        #1;
        check_eq("t6_sat_cnt", {16'b0, bubble_cnt}, 32'h0000_FFFF);
        check_eq("t6_sat_valid", {31'b0, ex_valid}, 32'd0);
        check_eq("t6_sat_stall", {31'b0, stall}, 32'd0);
        flush = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
